if_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC register and issues one word fetch at a time over a req/gnt/rvalid instruction-memory interface.
- Presents each fetched instruction and its PC to decode over a valid/ready handshake.
- Handles decode back-pressure (stall) and branch/jump redirects, including flushing wrong-path fetches still in flight.

---
 rtl/if_stage_pkg.sv | 23 ++
 rtl/if_pc_reg.sv | 38 +++
 rtl/if_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Bus widths, the reset fetch address and the fetch FSM state encodings.
package if_stage_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } if_state_e;

    function automatic addr_t word_align(input addr_t a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter: loads RESET_PC on reset, steps +4 on an accepted fetch, redirect wins.
// One-cycle update latency; no handshake of its own.
module if_pc_reg
    import if_stage_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  advance_i,
    input  logic  redirect_i,
    input  addr_t target_i,
    output addr_t pc_o
);

    addr_t pc_q;
    addr_t pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = word_align(target_i);
        end else if (advance_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction fetch: one outstanding imem request, output slot plus one-entry hold buffer.
// Latency gnt->if_valid = mem latency + 1; id_ready low parks a response in hold and stops fetching.
module if_stage
    import if_stage_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    output logic  imem_req,
    output addr_t imem_addr,
    input  logic  imem_gnt,
    input  logic  imem_rvalid,
    input  inst_t imem_rdata,
    input  logic  br_taken,
    input  addr_t br_target,
    output logic  if_valid,
    input  logic  id_ready,
    output inst_t inst,
    output addr_t if_pc
);

    if_state_e state_q, state_d;
    logic      req_q;
    addr_t     pc_q;
    addr_t     fetch_pc_q;
    logic      discard_q;
    logic      hold_valid_q;
    inst_t     hold_inst_q;
    addr_t     hold_pc_q;
    logic      if_valid_q;
    inst_t     inst_q;
    addr_t     if_pc_q;

    logic accept;
    logic slot_free;
    logic resp_ok;
    logic deliver_new;
    logic capture;
    logic drain;

    // req_q mirrors state==S_REQ but is held low through reset, so gnt is only honoured when requested.
    assign accept      = req_q & imem_gnt;
    assign slot_free   = ~if_valid_q | id_ready;
    assign resp_ok     = (state_q == S_WAIT) & imem_rvalid & ~discard_q & ~br_taken;
    assign deliver_new = resp_ok & slot_free;
    assign capture     = resp_ok & ~slot_free;
    assign drain       = hold_valid_q & id_ready & ~br_taken;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance_i  (accept),
        .redirect_i (br_taken),
        .target_i   (br_target),
        .pc_o       (pc_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:  if (accept) state_d = S_WAIT;
            S_WAIT: if (imem_rvalid) state_d = capture ? S_HOLD : S_REQ;
            S_HOLD: if (id_ready || br_taken) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            req_q        <= 1'b0;
            fetch_pc_q   <= '0;
            discard_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_inst_q  <= '0;
            hold_pc_q    <= '0;
            if_valid_q   <= 1'b0;
            inst_q       <= '0;
            if_pc_q      <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == S_REQ);

            if (accept) fetch_pc_q <= pc_q;

            // A redirect with a fetch in flight marks its eventual response as wrong-path.
            case (state_q)
                S_REQ: begin
                    if (accept) discard_q <= br_taken;
                end
                S_WAIT: begin
                    if (imem_rvalid)   discard_q <= 1'b0;
                    else if (br_taken) discard_q <= 1'b1;
                end
                default: discard_q <= 1'b0;
            endcase

            if (if_valid_q && id_ready) if_valid_q <= 1'b0;

            if (deliver_new) begin
                if_valid_q <= 1'b1;
                inst_q     <= imem_rdata;
                if_pc_q    <= fetch_pc_q;
            end

            if (capture) begin
                hold_valid_q <= 1'b1;
                hold_inst_q  <= imem_rdata;
                hold_pc_q    <= fetch_pc_q;
            end

            if (drain) begin
                if_valid_q   <= 1'b1;
                inst_q       <= hold_inst_q;
                if_pc_q      <= hold_pc_q;
                hold_valid_q <= 1'b0;
            end

            if (br_taken) begin
                if_valid_q   <= 1'b0;
                hold_valid_q <= 1'b0;
            end
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign inst      = inst_q;
    assign if_pc     = if_pc_q;

endmodule
